// File: rtl/bounded_updown_counter_if.sv
// Control and status bundle for bounded_updown_counter.
// The master side drives the count controls and the slave (the counter) returns
// the registered count and the status flags.
interface bounded_updown_counter_if #(
  parameter int WIDTH = 6
) ();
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, up, load, load_val,
    input  q, tc, wrap, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output q, tc, wrap, load_err
  );
endinterface

// File: rtl/bounded_updown_counter.sv
// Bounded up/down modulo counter over the closed range [LOW, HIGH].
// Per edge the priority is rst > load > en > hold. A load is clamped into the
// range and flagged on load_err; running past either end wraps and is flagged
// on wrap. Both flags are one-cycle registered pulses. tc is combinational so
// that a second counter can be cascaded by driving its en from this tc.
// The interface instance must be built with the same WIDTH as this module.
module bounded_updown_counter #(
  parameter int WIDTH   = 6,
  parameter int LOW     = 10,
  parameter int HIGH    = 35,
  parameter int RST_VAL = 35
) (
  input  logic                   clk,
  input  logic                   rst,
  bounded_updown_counter_if.slave bus
);

  // Reject parameter sets that would let q leave the range or not fit WIDTH.
  if (LOW < 0 || LOW >= HIGH) begin : g_bad_bounds
    $error("bounded_updown_counter: need 0 <= LOW < HIGH");
  end
  if (longint'(HIGH) > (longint'(1) << WIDTH) - 1) begin : g_bad_width
    $error("bounded_updown_counter: HIGH does not fit in WIDTH bits");
  end
  if (RST_VAL < LOW || RST_VAL > HIGH) begin : g_bad_rst_val
    $error("bounded_updown_counter: RST_VAL outside [LOW, HIGH]");
  end

  localparam logic [WIDTH-1:0] LOW_Q  = WIDTH'(LOW);
  localparam logic [WIDTH-1:0] HIGH_Q = WIDTH'(HIGH);
  localparam logic [WIDTH-1:0] RST_Q  = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             wrap;
  logic             wrap_next;
  logic             load_err;
  logic             load_err_next;

  // Next count and flags from load/en/up; reset is applied in the register.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    q_next        = q;
    wrap_next     = 1'b0;
    load_err_next = 1'b0;
    if (bus.load) begin
      if (bus.load_val < LOW_Q) begin
        q_next        = LOW_Q;
        load_err_next = 1'b1;
      end else if (bus.load_val > HIGH_Q) begin
        q_next        = HIGH_Q;
        load_err_next = 1'b1;
      end else begin
        q_next = bus.load_val;
      end
    end else if (bus.en) begin
      // The bound test comes first, so +1 / -1 can never overflow WIDTH bits.
      if (bus.up) begin
        if (q == HIGH_Q) begin
          q_next    = LOW_Q;
          wrap_next = 1'b1;
        end else begin
          q_next = q + 1'b1;
        end
      end else begin
        if (q == LOW_Q) begin
          q_next    = HIGH_Q;
          wrap_next = 1'b1;
        end else begin
          q_next = q - 1'b1;
        end
      end
    end
  end

  // State register with synchronous reset; rst overrides load and en.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      q        <= RST_Q;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= q_next;
      wrap     <= wrap_next;
      load_err <= load_err_next;
    end
  end

  assign bus.q        = q;
  assign bus.wrap     = wrap;
  assign bus.load_err = load_err;
  assign bus.tc       = bus.en & ((bus.up & (q == HIGH_Q)) | (~bus.up & (q == LOW_Q)));

endmodule
